cp0_exc_ctrl: RTL

Coprocessor-0 exception and interrupt sequencer for the 5-stage MIPS pipeline. It consumes the decoder's `s_syscall`, `s_eret`, `s_mtc0` and `s_mfc0` strobes for the instruction in EX, together with external interrupt lines. It arbitrates syscalls and prioritised interrupts, and holds the Status, Cause and EPC registers. It also produces a one-cycle flush/redirect command to the fetch stage.

---
 rtl/cp0_exc_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception and interrupt sequencer.
// Holds Status/Cause/EPC, latches edge-triggered interrupt requests, arbitrates syscall vs
// prioritised interrupts and issues a registered one-cycle flush/redirect to fetch.
module cp0_exc_ctrl #(
  parameter int unsigned N_IRQ        = 3,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             ex_valid_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             s_syscall_i,
  input  logic             s_eret_i,
  input  logic             s_mtc0_i,
  input  logic             s_mfc0_i,
  input  logic [4:0]       cp0_sel_i,
  input  logic [31:0]      cp0_wdata_i,
  output logic [31:0]      cp0_rdata_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [31:0]      epc_o,
  output logic             in_handler_o
);

  localparam logic [4:0] SelStatus = 5'd12;
  localparam logic [4:0] SelCause  = 5'd13;
  localparam logic [4:0] SelEpc    = 5'd14;
  localparam logic [4:0] ExcInt    = 5'd0;
  localparam logic [4:0] ExcSys    = 5'd8;

  typedef enum logic [1:0] {StIdle, StEnter, StHandler, StLeave} state_e;

  state_e             state_q;
  logic               redirect_q;
  logic [31:0]        redirect_pc_q;
  logic [31:0]        epc_q;
  logic               in_handler_q;
  logic               ie_q;
  logic [N_IRQ-1:0]   im_q;
  logic [4:0]         exc_code_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   irq_prev_q;

  logic [N_IRQ-1:0]   elig;
  logic [N_IRQ-1:0]   grant;
  logic               take_sys;
  logic               take_irq;
  logic               take_exc;
  logic               take_eret;
  logic               mtc0_we;
  logic [31:0]        status_rd;
  logic [31:0]        cause_rd;

  // Entry/exit decode and lowest-index-first interrupt arbitration.
  always_comb begin
    elig      = pending_q & im_q & {N_IRQ{ie_q}};
    // Isolate the lowest set bit: highest-priority eligible line.
    grant     = elig & (~elig + N_IRQ'(1));
    take_sys  = (state_q == StIdle) && ex_valid_i && s_syscall_i;
    take_irq  = (state_q == StIdle) && ex_valid_i && !s_syscall_i && (|elig);
    take_exc  = take_sys || take_irq;
    take_eret = (state_q == StHandler) && ex_valid_i && s_eret_i;
    // An mtc0 alongside an entry is flushed and replayed, so it must not commit.
    mtc0_we   = ex_valid_i && s_mtc0_i && !take_exc &&
                ((state_q == StIdle) || (state_q == StHandler));
    // A new rising edge wins over a grant clear in the same cycle.
    pending_d = (pending_q & ~(take_irq ? grant : '0)) | (irq_i & ~irq_prev_q);
  end

  // Interrupt edge detection and pending latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_i;
      pending_q  <= pending_d;
    end
  end

  // Sequencer FSM with registered outputs, plus Status/Cause/EPC updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      in_handler_q  <= 1'b0;
      ie_q          <= 1'b0;
      im_q          <= '0;
      exc_code_q    <= '0;
    end else begin
      redirect_q <= 1'b0;

      if (mtc0_we) begin
        unique case (cp0_sel_i)
          SelStatus: begin
            ie_q <= cp0_wdata_i[0];
            im_q <= cp0_wdata_i[8 +: N_IRQ];
          end
          SelEpc:  epc_q <= cp0_wdata_i;
          default: ;
        endcase
      end

      unique case (state_q)
        StIdle: begin
          if (take_exc) begin
            state_q       <= StEnter;
            redirect_q    <= 1'b1;
            redirect_pc_q <= HANDLER_ADDR;
            in_handler_q  <= 1'b1;
            ie_q          <= 1'b0;
            epc_q         <= take_sys ? (ex_pc_i + 32'd4) : ex_pc_i;
            exc_code_q    <= take_sys ? ExcSys : ExcInt;
          end
        end
        StEnter: begin
          state_q <= StHandler;
        end
        StHandler: begin
          if (take_eret) begin
            state_q       <= StLeave;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
            in_handler_q  <= 1'b0;
            ie_q          <= 1'b1;
          end
        end
        StLeave: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // mfc0 read mux; shows register state ahead of the current edge.
  always_comb begin
    status_rd               = '0;
    status_rd[0]            = ie_q;
    status_rd[8 +: N_IRQ]   = im_q;
    cause_rd                = '0;
    cause_rd[6:2]           = exc_code_q;
    cause_rd[8 +: N_IRQ]    = pending_q;
    cp0_rdata_o             = '0;
    if (ex_valid_i && s_mfc0_i) begin
      unique case (cp0_sel_i)
        SelStatus: cp0_rdata_o = status_rd;
        SelCause:  cp0_rdata_o = cause_rd;
        SelEpc:    cp0_rdata_o = epc_q;
        default:   cp0_rdata_o = '0;
      endcase
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign epc_o         = epc_q;
  assign in_handler_o  = in_handler_q;

endmodule
